// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide unit that writes its result
// back through a register-file write port using a valid/ready handshake.
//
// Operations (op): 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR.
// Each operation takes WIDTH iterations, one per clock. The result is then
// held on the write-back port until the register file accepts it.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   start        request a new operation (only accepted in IDLE)
//   op           operation select
//   src_a        operand A (multiplicand / dividend)
//   src_b        operand B (multiplier / divisor)
//   dest         destination register index
//   busy         high whenever the unit is not IDLE
//   wb_valid     result available on wb_dest / wb_data
//   wb_ready     write port accepts the result this cycle
//   wb_dest      write-back register index (0 when wb_valid=0)
//   wb_data      write-back data (0 when wb_valid=0)
//   div_by_zero  with wb_valid: the divide had a zero divisor
module mul_div_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data,
    output logic              div_by_zero
);

    localparam int         RW       = WIDTH + 1;
    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [4:0]          cnt_reg, cnt_next;
    logic [1:0]          op_reg, op_next;
    logic [WIDTH-1:0]    b_reg, b_next;
    logic [ADDR_W-1:0]   dest_reg, dest_next;
    // Multiply: {partial sum, remaining multiplier bits}. src_a is loaded into
    // the low half and src_b is the addend; the product is symmetric.
    logic [2*WIDTH-1:0]  prod_reg, prod_next;
    // Divide: remainder and quotient (quotient starts as the dividend and
    // shifts out one dividend bit per iteration while quotient bits shift in).
    logic [WIDTH:0]      rem_reg, rem_next;
    logic [WIDTH-1:0]    quo_reg, quo_next;

    logic [WIDTH:0]      mul_sum;
    logic [WIDTH+1:0]    div_shift;
    logic                div_ge;
    logic [WIDTH-1:0]    result;

    // One shift-add step: add the multiplicand to the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + (prod_reg[0] ? {1'b0, b_reg} : {RW{1'b0}});

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {2'b00, b_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            b_reg     <= '0;
            dest_reg  <= '0;
            prod_reg  <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            b_reg     <= b_next;
            dest_reg  <= dest_next;
            prod_reg  <= prod_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        b_next     = b_reg;
        dest_next  = dest_reg;
        prod_next  = prod_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = '0;
                    op_next    = op;
                    b_next     = src_b;
                    dest_next  = dest;
                    prod_next  = {{WIDTH{1'b0}}, src_a};
                    rem_next   = '0;
                    quo_next   = src_a;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 5'd1;
                if (!op_reg[1]) begin
                    prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
                end else begin
                    rem_next = div_ge ? RW'(div_shift - {2'b00, b_reg})
                                      : div_shift[WIDTH:0];
                    quo_next = {quo_reg[WIDTH-2:0], div_ge};
                end
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end
            end
            DONE: begin
                // start is deliberately ignored here, even on the
                // handshake cycle; a new operation needs a cycle in IDLE.
                if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        case (op_reg)
            2'b00:   result = prod_reg[WIDTH-1:0];
            2'b01:   result = prod_reg[2*WIDTH-1:WIDTH];
            2'b10:   result = quo_reg;
            default: result = rem_reg[WIDTH-1:0];
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign wb_valid    = (state_reg == DONE);
    assign wb_dest     = wb_valid ? dest_reg : '0;
    assign div_by_zero = wb_valid && op_reg[1] && (b_reg == '0);

    // Write data is forced to zero whenever no result is being offered.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wb_data
            assign wb_data[gi] = wb_valid & result[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [AW-1:0] dest;
    logic          busy;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_dest;
    logic [W-1:0]  wb_data;
    logic          div_by_zero;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .dest        (dest),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] dst;
        logic          dbz;
    } exp_t;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] d;
        logic [W-1:0]  exp_data;
        logic          exp_dbz;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_xfer   = 0;
    int   n_ops    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted write transfer must match the oldest
    // outstanding expectation. A reset cycle is never a transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_transfer", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                n_xfer++;
                $display("xfer %0d: dest=%0d data=0x%04h dbz=%0b (exp dest=%0d data=0x%04h dbz=%0b)",
                         n_xfer, wb_dest, wb_data, div_by_zero, e.dst, e.data, e.dbz);
                check("xfer_data", 32'(wb_data), 32'(e.data));
                check("xfer_dest", 32'(wb_dest), 32'(e.dst));
                check("xfer_dbz", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    // Called #1 after a rising edge with the unit IDLE. Runs one operation,
    // scrambles the operand inputs and pulses start during BUSY, optionally
    // holds wb_ready low for 'hold' cycles and optionally raises start on the
    // handshake cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input logic [W-1:0] exp_d, input logic exp_z,
                         input int hold, input bit hs_start);
        int lat;
        n_ops++;
        start    = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        dest     = d;
        wb_ready = (hold == 0);
        @(posedge clk); #1;
        sb_q.push_back('{exp_d, d, exp_z});
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!wb_valid && lat < 40) begin
            start = (lat == 5);
            op    = 2'($urandom);
            src_a = W'($urandom);
            src_b = W'($urandom);
            dest  = AW'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'd16);
        check("done_data", 32'(wb_data), 32'(exp_d));
        check("done_dest", 32'(wb_dest), 32'(d));
        check("done_dbz", 32'(div_by_zero), 32'(exp_z));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(wb_valid), 32'd1);
            check("hold_data", 32'(wb_data), 32'(exp_d));
            check("hold_dest", 32'(wb_dest), 32'(d));
            check("hold_dbz", 32'(div_by_zero), 32'(exp_z));
        end
        wb_ready = 1'b1;
        if (hs_start) begin
            start = 1'b1;
            op    = 2'b00;
            src_a = 16'd3;
            src_b = 16'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(wb_valid), 32'd0);
        check("idle_data", 32'(wb_data), 32'd0);
    endtask

    // Reference model for the randomised operations.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (o)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (b == 0) ? 16'hFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;
        int           lat;

        vecs[0] = '{2'b00, 16'd300,   16'd250,   3'd1, 16'h24F8, 1'b0};
        vecs[1] = '{2'b01, 16'd300,   16'd250,   3'd2, 16'h0001, 1'b0};
        vecs[2] = '{2'b00, 16'hFFFF,  16'hFFFF,  3'd3, 16'h0001, 1'b0};
        vecs[3] = '{2'b01, 16'hFFFF,  16'hFFFF,  3'd5, 16'hFFFE, 1'b0};
        vecs[4] = '{2'b10, 16'd1000,  16'd7,     3'd4, 16'h008E, 1'b0};
        vecs[5] = '{2'b11, 16'd1000,  16'd7,     3'd4, 16'h0006, 1'b0};
        vecs[6] = '{2'b10, 16'd1234,  16'd0,     3'd6, 16'hFFFF, 1'b1};
        vecs[7] = '{2'b11, 16'd1234,  16'd0,     3'd7, 16'h04D2, 1'b1};

        rst      = 1'b1;
        start    = 1'b1;
        op       = 2'b00;
        src_a    = 16'd5;
        src_b    = 16'd5;
        dest     = 3'd1;
        wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(wb_valid), 32'd0);
        check("reset_data", 32'(wb_data), 32'd0);
        check("reset_dest", 32'(wb_dest), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        // Table vectors; vector 2 holds wb_ready low for 5 cycles, vector 3
        // raises start on its handshake cycle.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp_data,
                  vecs[i].exp_dbz, (i == 2) ? 5 : 0, (i == 3));
        end

        // Randomised operations checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            ro = 2'(i % 4);
            ra = W'($urandom);
            rb = (i % 5 == 0) ? 16'd0 : ((i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom));
            do_op(ro, ra, rb, AW'(i), model(ro, ra, rb), ro[1] && (rb == 0), i % 3, 1'b0);
        end

        // Reset at iteration 8 of an operation, with wb_ready high: no transfer.
        wb_ready = 1'b1;
        start    = 1'b1;
        op       = 2'b10;
        src_a    = 16'd999;
        src_b    = 16'd3;
        dest     = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(wb_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(wb_valid), 32'd0);
        end

        // Reset in DONE with wb_ready raised in the same cycle: no transfer.
        wb_ready = 1'b0;
        start    = 1'b1;
        op       = 2'b00;
        src_a    = 16'd7;
        src_b    = 16'd9;
        dest     = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (!wb_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_abort_latency", 32'(lat), 32'd16);
        check("done_abort_data", 32'(wb_data), 32'd63);
        rst      = 1'b1;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("done_abort_busy", 32'(busy), 32'd0);
        check("done_abort_valid", 32'(wb_valid), 32'd0);
        check("done_abort_data0", 32'(wb_data), 32'd0);
        check("done_abort_dest0", 32'(wb_dest), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_abort_no_valid", 32'(wb_valid), 32'd0);

        // The unit must still work normally after the aborts.
        do_op(2'b10, 16'd1000, 16'd7, 3'd4, 16'h008E, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("transfer_count", 32'(n_xfer), 32'(n_ops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
